io_responder: RTL
=================

// Module: io_responder
// PURPOSE
//  Peripheral-side responder for the control unit's IN/OUT instructions.
//  - IN: while the CPU waits on in_req (controleIN), this block captures the switch value
//    on a debounced button press and raises in_ack (the CPU's enter).
//  - OUT: on out_req (controleOUT), it latches out_data and shows it on a scanned
//    hex 7-segment display.
//  Sits between the datapath and board I/O (switches, push button, 7-seg, LED).
// PARAMETERS
//  DATA_W           32      width of in_data/out_data (datapath word)
//  SW_W             16      switch count; zero-extended into in_data
//  DEBOUNCE_CYCLES  250000  stable-level cycles required to accept a btn change
//  REFRESH_CYCLES   50000   clk cycles per display digit slot
//  NUM_DIGITS       4       hex digits shown (low 4*NUM_DIGITS bits of out latch)
// PORTS
//  clk        in   1           system clock, all logic on posedge
//  reset      in   1           synchronous, active-high
//  in_req     in   1           CPU waiting for input (level, held until in_ack seen)
//  in_ack     out  1           input valid / enter to control unit
//  in_data    out  DATA_W      captured input word {0, sw}
//  sw         in   SW_W        board switches (asynchronous)
//  btn        in   1           board enter button (asynchronous, active-high)
//  out_req    in   1           CPU output strobe (>=1 cycle)
//  out_data   in   DATA_W      word to display
//  seg        out  7           segments a..g, active-low
//  an         out  NUM_DIGITS  digit enables, active-low, one-hot-cold
//  led_wait   out  1           high while an input request is pending
// BEHAVIOUR
//  Reset: in_ack=0, in_data=0, out latch=0, seg=7'h7F, an=all 1s, led_wait=0, FSM=IDLE,
//    scan counter/digit=0, debounced btn=0.
//  Reset mid-transfer: abandons the handshake; in_ack drops on the next cycle.
//  btn and sw pass through 2-flop synchronizers.
//  Press event = debounced-btn rising edge, one cycle wide.
//  FSM (registered outputs):
//   IDLE:    in_ack=0. in_req=1 -> WAIT. A press in IDLE is discarded.
//   WAIT:    led_wait=1. On press with in_req=1: in_data<={0,sw_sync} and in_ack<=1 in the
//            same edge -> ACK.
//            in_req falls before press -> IDLE, no capture.
//   ACK:     in_ack held 1 until in_req=0, then in_ack<=0 -> REL.
//            Level handshake tolerates the CPU's negedge sampling.
//   REL:     waits for debounced btn=0, then -> IDLE.
//            One press satisfies at most one IN instruction.
//  Latency: in_ack rises 1 cycle after the press event. in_data is stable from in_ack
//    rise until the next capture.
//  Simultaneous press and in_req rise in IDLE: press ignored; user must press again.
//  OUT: out latch <= out_data on every cycle out_req=1.
//   - Back-to-back OUTs: last value wins.
//   - Independent of the IN FSM; an OUT during WAIT is legal.
//  Scan: counter 0..REFRESH_CYCLES-1, then wraps and digit index advances mod NUM_DIGITS.
//   - an[i]=0 only for the active digit.
//   - seg = hex decode of nibble i of the latch.
//  DEBOUNCE_CYCLES compare uses a counter width of $clog2(DEBOUNCE_CYCLES+1). The counter
//   saturates and never wraps.
// CONFIGURATION
//  IO_DEBOUNCE_EN defined: btn is filtered. The debounced level changes only after the
//    synchronized btn differs from it for DEBOUNCE_CYCLES consecutive cycles.
//  Not defined: debounced btn = synchronized btn (for simulation / clean sources).
//    DEBOUNCE_CYCLES is ignored.
// STRUCTURE
//  io_pkg:
//   - io_state_t enum {IDLE, WAIT, ACK, REL}
//   - HEX7SEG[16] active-low segment constant table
//  Sub-module btn_debounce: sync + optional filter + rise-pulse output.
//    Instantiated once.
//  Display scan and FSM stay in io_responder.
// TESTING
//  1 in_req=1, sw=16'hBEEF, clean btn pulse -> in_ack=1 one cycle after debounced edge;
//    in_data=32'h0000BEEF; in_ack held until in_req=0, then 0 next cycle.
//  2 btn held high across two consecutive in_req periods -> only the first gets in_ack;
//    the second needs release and a new press.
//  3 IO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8, btn glitch 5 cycles high -> no in_ack;
//    then a 10-cycle press -> in_ack.
//  4 out_req=1 for 1 cycle with out_data=32'h00001234, REFRESH_CYCLES=4 -> an walks
//    1110,1101,1011,0111 every 4 cycles; seg shows 4,3,2,1 codes.
//  5 reset asserted while in ACK -> next cycle in_ack=0, led_wait=0, an=1111, seg=7F,
//    FSM IDLE.
//  6 out_req pulse during WAIT -> display updates; in handshake unaffected and still
//    completes on press.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and constants for the IN/OUT peripheral responder.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } io_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX7SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
    return HEX7SEG[nibble];
  endfunction

endpackage

// File: rtl/io_responder_btn_debounce.sv
// Enter-button conditioner: 2-flop synchronizer, optional stability filter
// (enabled by IO_DEBOUNCE_EN), and a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  logic meta_r;
  logic sync_r;
  logic deb_r;
  logic deb_nxt_s;
  logic press_r;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement
  always_comb begin
    cnt_nxt_s = cnt_r;
    deb_nxt_s = deb_r;
    if (sync_r == deb_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r >= CNT_LAST) begin
      deb_nxt_s = sync_r;
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stability counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  // Unfiltered: debounced level follows the synchronizer directly
  always_comb begin
    deb_nxt_s = sync_r;
  end
`endif

  // Debounced level and its rising-edge pulse, aligned to the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_r   <= 1'b0;
      press_r <= 1'b0;
    end else begin
      deb_r   <= deb_nxt_s;
      press_r <= deb_nxt_s & ~deb_r;
    end
  end

  assign level = deb_r;
  assign press = press_r;

endmodule

// File: rtl/io_responder.sv
// Peripheral responder for IN/OUT: button-entered switch capture with a level
// handshake, and a scanned hex display of the last OUT word. Macro: IO_DEBOUNCE_EN.
module io_responder
  import io_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REFRESH_CYCLES  = 50000,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_req,
  output logic                  in_ack,
  output logic [DATA_W-1:0]     in_data,
  input  logic [SW_W-1:0]       sw,
  input  logic                  btn,
  input  logic                  out_req,
  input  logic [DATA_W-1:0]     out_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  led_wait
);

  localparam int SCAN_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(REFRESH_CYCLES - 1);
  localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [SW_W-1:0]       sw_meta_r;
  logic [SW_W-1:0]       sw_sync_r;
  logic                  btn_level_s;
  logic                  press_s;
  io_state_t             state_r;
  io_state_t             state_nxt_s;
  logic                  in_ack_r;
  logic                  in_ack_nxt_s;
  logic [DATA_W-1:0]     in_data_r;
  logic [DATA_W-1:0]     in_data_nxt_s;
  logic                  led_wait_r;
  logic [DATA_W-1:0]     out_latch_r;
  logic [SCAN_W-1:0]     scan_cnt_r;
  logic [DIG_W-1:0]      digit_r;
  logic [3:0]            nibble_s;
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .level(btn_level_s),
    .press(press_s)
  );

  // Switch synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_r <= {SW_W{1'b0}};
      sw_sync_r <= {SW_W{1'b0}};
    end else begin
      sw_meta_r <= sw;
      sw_sync_r <= sw_meta_r;
    end
  end

  // IN handshake next-state; REL blocks a held button from serving a second IN
  always_comb begin
    state_nxt_s   = state_r;
    in_ack_nxt_s  = in_ack_r;
    in_data_nxt_s = in_data_r;
    case (state_r)
      IDLE: begin
        in_ack_nxt_s = 1'b0;
        if (in_req) state_nxt_s = WAIT;
        else        state_nxt_s = IDLE;
      end
      WAIT: begin
        if (!in_req) begin
          state_nxt_s = IDLE;
        end else if (press_s) begin
          in_data_nxt_s = DATA_W'(sw_sync_r);
          in_ack_nxt_s  = 1'b1;
          state_nxt_s   = ACK;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      ACK: begin
        if (!in_req) begin
          in_ack_nxt_s = 1'b0;
          state_nxt_s  = REL;
        end else begin
          in_ack_nxt_s = 1'b1;
          state_nxt_s  = ACK;
        end
      end
      REL: begin
        in_ack_nxt_s = 1'b0;
        if (!btn_level_s) state_nxt_s = IDLE;
        else              state_nxt_s = REL;
      end
      default: begin
        in_ack_nxt_s = 1'b0;
        state_nxt_s  = IDLE;
      end
    endcase
  end

  // IN handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      in_ack_r   <= 1'b0;
      in_data_r  <= {DATA_W{1'b0}};
      led_wait_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ack_r   <= in_ack_nxt_s;
      in_data_r  <= in_data_nxt_s;
      led_wait_r <= (state_nxt_s == WAIT);
    end
  end

  // OUT latch; last strobed value wins
  always_ff @(posedge clk) begin
    if (reset) begin
      out_latch_r <= {DATA_W{1'b0}};
    end else if (out_req) begin
      out_latch_r <= out_data;
    end else begin
      out_latch_r <= out_latch_r;
    end
  end

  // Digit slot timer and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      digit_r    <= {DIG_W{1'b0}};
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      digit_r    <= (digit_r == DIGIT_LAST) ? {DIG_W{1'b0}} : digit_r + DIG_W'(1);
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      digit_r    <= digit_r;
    end
  end

  // Nibble of the latch for the active digit
  always_comb begin
    nibble_s = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_r == DIG_W'(i)) nibble_s = out_latch_r[4*i +: 4];
      else                      nibble_s = nibble_s;
    end
  end

  // Registered display drive
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= SEG_BLANK;
      an_r  <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r <= hex7seg(nibble_s);
      an_r  <= ~(NUM_DIGITS'(1) << digit_r);
    end
  end

  assign in_ack   = in_ack_r;
  assign in_data  = in_data_r;
  assign led_wait = led_wait_r;
  assign seg      = seg_r;
  assign an       = an_r;

endmodule
